eth_rx_pkt_buf: RTL and testbench

ETH_RX_PKT_BUF -- requirements
Module: eth_rx_pkt_buf

---
 rtl/eth_rx_pkt_buf_pkg.sv | 29 ++
 rtl/eth_rx_pkt_buf_mem.sv | 39 +++
 rtl/eth_rx_pkt_buf.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_rx_pkt_buf.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkt_buf_pkg.sv
// eth_rx_pkt_buf_pkg
//   Shared types for the Ethernet receive packet buffer:
//   - wr_state_e : write-side frame FSM states
//   - word_sb_t  : per-word sideband (lane keep mask, last-of-frame flag)
//   - lane_mask  : keep mask covering lanes 0..upto
package eth_rx_pkt_buf_pkg;

  localparam int unsigned MAX_NBYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [MAX_NBYTES-1:0] keep;
    logic                  last;
  } word_sb_t;

  function automatic logic [MAX_NBYTES-1:0] lane_mask(input int upto);
    logic [MAX_NBYTES-1:0] m;
    for (int k = 0; k < MAX_NBYTES; k++) begin
      m[k] = (k <= upto);
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_rx_pkt_buf_mem.sv
// eth_rx_pkt_buf_mem
//   Single-clock one-write / one-read synchronous RAM. Read data appears on
//   rdata_o the cycle after re_i. No reset on the array or read register so a
//   two-port hard macro can be dropped in with the same port list.
// Ports
//   clk_i    clock
//   we_i     write enable, waddr_i / wdata_i
//   re_i     read enable, raddr_i
//   rdata_o  registered read data
module eth_rx_pkt_buf_mem
  import eth_rx_pkt_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_pkt_buf.sv
// eth_rx_pkt_buf
//   Store-and-forward receive buffer. Bytes from the MAC are packed into
//   NBYTES-wide words and written to RAM; a frame becomes visible to the read
//   side only once its last byte arrives error-free. Bad or overflowing frames
//   are rewound and counted.
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   rx_data_i/valid_i/last_i/err_i     byte stream from MAC (no backpressure)
//   m_data_o/keep_o/last_o             output word, lane 0 = earliest byte
//   m_valid_o/m_ready_i                output handshake
//   fill_o                             committed words not yet read from RAM
//   drop_cnt_o                         saturating dropped-frame count
//
// Write FSM
//   state   | meaning
//   IDLE    | between frames, next byte starts a frame
//   RECV    | storing bytes of the current frame
//   DROP    | overflowed, discarding bytes until the last one
module eth_rx_pkt_buf
  import eth_rx_pkt_buf_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     rx_last_i,
  input  logic                     rx_err_i,
  output logic [8*NBYTES-1:0]      m_data_o,
  output logic [NBYTES-1:0]        m_keep_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(NBYTES);
  localparam int unsigned DW = 8 * NBYTES;
  localparam int unsigned MW = 9 * NBYTES + 1;

  wr_state_e         state_q, state_d;
  logic [BW-1:0]     b_idx_q, b_idx_d;
  logic [DW-1:0]     pack_q, pack_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              pend_q, pend_d;
  logic              m_valid_q, m_valid_d;
  logic [MW-1:0]     m_word_q, m_word_d;
  logic              skid_valid_q, skid_valid_d;
  logic [MW-1:0]     skid_q, skid_d;

  logic [DW-1:0]     wr_word;
  word_sb_t          wr_sb;
  logic              sb_unused;
  logic              need_wr;
  logic              full;
  logic              drop_inc;
  logic              mem_we;
  logic [MW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_rdata;

  logic              pop;
  logic [1:0]        occ;
  logic              rd_avail;
  logic              rd_en;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_word = pack_q;
    wr_word[8*b_idx_q +: 8] = rx_data_i;
    wr_sb.keep = lane_mask(int'(b_idx_q));
    wr_sb.last = rx_last_i;
  end

  // Upper keep lanes beyond NBYTES are always zero and never stored.
  assign sb_unused = |(wr_sb.keep >> NBYTES);

  assign mem_wdata = {wr_sb.last, wr_sb.keep[NBYTES-1:0], wr_word};
  assign need_wr   = (b_idx_q == BW'(NBYTES-1)) || rx_last_i;
  // Compared against the RAM read pointer, so words already fetched into the
  // output stage free their slot immediately.
  assign full      = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    b_idx_d      = b_idx_q;
    pack_d       = pack_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_inc     = 1'b0;
    mem_we       = 1'b0;

    if (rx_valid_i) begin
      case (state_q)
        ST_IDLE, ST_RECV: begin
          if (need_wr) begin
            b_idx_d = '0;
            pack_d  = '0;
            if (full) begin
              if (rx_last_i) begin
                wr_ptr_d = commit_ptr_q;
                drop_inc = 1'b1;
                state_d  = ST_IDLE;
              end else begin
                state_d  = ST_DROP;
              end
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (rx_last_i) begin
                state_d = ST_IDLE;
                if (rx_err_i) begin
                  wr_ptr_d = commit_ptr_q;
                  drop_inc = 1'b1;
                end else begin
                  commit_ptr_d = wr_ptr_q + PW'(1);
                end
              end else begin
                state_d = ST_RECV;
              end
            end
          end else begin
            pack_d  = wr_word;
            b_idx_d = b_idx_q + BW'(1);
            state_d = ST_RECV;
          end
        end
        ST_DROP: begin
          if (rx_last_i) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: RAM read, then a two-entry output stage (head + skid).
  // A read is issued only if the stage can absorb it next cycle, counting the
  // read already in flight, which keeps 1 word/cycle with m_ready_i high.
  // ---------------------------------------------------------------------------
  always_comb begin
    pop      = m_valid_q & m_ready_i;
    occ      = {1'b0, m_valid_q} + {1'b0, skid_valid_q};
    rd_avail = (rd_ptr_q != commit_ptr_q);
    rd_en    = rd_avail && ((occ + {1'b0, pend_q}) < (2'd2 + {1'b0, pop}));
    rd_ptr_d = rd_en ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    pend_d   = rd_en;

    m_valid_d    = m_valid_q;
    m_word_d     = m_word_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (skid_valid_q) begin
      if (pop) begin
        m_word_d     = skid_q;
        skid_valid_d = pend_q;
        if (pend_q) begin
          skid_d = mem_rdata;
        end
      end
    end else if (m_valid_q && !pop) begin
      if (pend_q) begin
        skid_d       = mem_rdata;
        skid_valid_d = 1'b1;
      end
    end else begin
      m_valid_d = pend_q;
      if (pend_q) begin
        m_word_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      b_idx_q      <= '0;
      pack_q       <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
      pend_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_word_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      b_idx_q      <= b_idx_d;
      pack_q       <= pack_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      pend_q       <= pend_d;
      m_valid_q    <= m_valid_d;
      m_word_q     <= m_word_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  eth_rx_pkt_buf_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (mem_wdata),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign m_data_o   = m_word_q[DW-1:0];
  assign m_keep_o   = m_word_q[DW +: NBYTES];
  assign m_last_o   = m_word_q[MW-1];
  assign m_valid_o  = m_valid_q;
  assign fill_o     = commit_ptr_q - rd_ptr_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_pkt_buf.sv
module tb_eth_rx_pkt_buf;

  localparam int NB = 4;
  localparam int DP = 8;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_last;
  logic          rx_err;
  logic [8*NB-1:0] m_data;
  logic [NB-1:0] m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [$clog2(DP):0] fill;
  logic [15:0]   drop_cnt;

  eth_rx_pkt_buf #(.NBYTES(NB), .DEPTH(DP)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_last_i  (rx_last),
    .rx_err_i   (rx_err),
    .m_data_o   (m_data),
    .m_keep_o   (m_keep),
    .m_last_o   (m_last),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .fill_o     (fill),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_keep[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  logic [7:0]  fb[$];
  int          exp_drop;
  int          checks;
  int          errors;
  int          cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Compare process: every transfer against the model queue, and output
  // stability while stalled.
  logic        stall_prev;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;
  initial stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(m_valid && m_data == prev_data && m_keep == prev_keep && m_last == prev_last)) begin
          errors++;
          $display("FAIL hold valid=%0b data=0x%0h keep=0x%0h last=%0b expected data=0x%0h keep=0x%0h last=%0b",
                   m_valid, m_data, m_keep, m_last, prev_data, prev_keep, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word data=0x%0h keep=0x%0h last=%0b expected none", m_data, m_keep, m_last);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last) begin
            errors++;
            $display("FAIL word data=0x%0h keep=0x%0h last=%0b expected data=0x%0h keep=0x%0h last=%0b",
                     m_data, m_keep, m_last, e.data, e.keep, e.last);
          end
        end
        obs_data.push_back(m_data);
        obs_keep.push_back(m_keep);
        obs_last.push_back(m_last);
        obs_cyc.push_back(cyc);
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      prev_last  = m_last;
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic last, input logic err);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = last;
    rx_err   = err;
  endtask

  task automatic rx_stop();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic mk_seq(input logic [7:0] start, input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(start + 8'(i));
  endtask

  // Sends fb as one frame; the model keeps it only if it is error-free and
  // fits in the buffer, and splits it into little-endian words.
  task automatic send_frame(input logic err);
    int    n;
    int    nw;
    word_t w;
    n  = fb.size();
    nw = (n + NB - 1) / NB;
    for (int i = 0; i < n; i++) drive_byte(fb[i], (i == n - 1), err && (i == n - 1));
    if (!err && nw <= DP) begin
      for (int wi = 0; wi < nw; wi++) begin
        w.data = '0;
        w.keep = '0;
        for (int l = 0; l < NB; l++) begin
          if (wi * NB + l < n) begin
            w.data[8*l +: 8] = fb[wi * NB + l];
            w.keep[l] = 1'b1;
          end
        end
        w.last = (wi == nw - 1);
        exp_q.push_back(w);
      end
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && (exp_q.size() != 0 || m_valid); i++) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_keep.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data",  m_data, 32'd0);
    chk("rst_keep",  32'(m_keep), 32'd0);
    chk("rst_last",  32'(m_last), 32'd0);
    chk("rst_fill",  32'(fill), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    exp_drop = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
    m_ready  = 1'b1;
    do_reset();

    // 6-byte good frame followed back-to-back by a single-byte frame
    clear_obs();
    mk_seq(8'h11, 6);
    for (int i = 0; i < 6; i++) fb[i] = 8'h11 * 8'(i + 1);
    send_frame(1'b0);
    fb.delete();
    fb.push_back(8'h5A);
    send_frame(1'b0);
    rx_stop();
    drain(60, "t31");
    chk("t31_nwords", 32'(obs_data.size()), 32'd3);
    if (obs_data.size() == 3) begin
      chk("t31_w0_data", obs_data[0], 32'h44332211);
      chk("t31_w0_keep", 32'(obs_keep[0]), 32'hF);
      chk("t31_w0_last", 32'(obs_last[0]), 32'd0);
      chk("t31_w1_data", obs_data[1], 32'h00006655);
      chk("t31_w1_keep", 32'(obs_keep[1]), 32'h3);
      chk("t31_w1_last", 32'(obs_last[1]), 32'd1);
      chk("t21_single_data", obs_data[2], 32'h0000005A);
      chk("t21_single_keep", 32'(obs_keep[2]), 32'h1);
    end
    chk("t31_fill", 32'(fill), 32'd0);
    chk("t31_drop", 32'(drop_cnt), 32'(exp_drop));

    // 5-byte frame with error on last byte
    mk_seq(8'h20, 5);
    send_frame(1'b1);
    rx_stop();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t32_valid", 32'(m_valid), 32'd0);
    chk("t32_drop",  32'(drop_cnt), 32'd1);
    chk("t32_drop_model", 32'(drop_cnt), 32'(exp_drop));
    chk("t32_fill",  32'(fill), 32'd0);

    // 40-byte frame overflows, then a short frame and an exactly-full frame
    do_reset();
    clear_obs();
    mk_seq(8'h80, 40);
    send_frame(1'b0);
    rx_stop();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t33_drop", 32'(drop_cnt), 32'd1);
    chk("t33_fill", 32'(fill), 32'd0);
    mk_seq(8'hA1, 4);
    send_frame(1'b0);
    rx_stop();
    drain(60, "t33");
    chk("t33_nwords", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() == 1) begin
      chk("t33_data", obs_data[0], 32'hA4A3A2A1);
      chk("t33_keep", 32'(obs_keep[0]), 32'hF);
      chk("t33_last", 32'(obs_last[0]), 32'd1);
    end
    clear_obs();
    mk_seq(8'h40, 4 * DP);
    send_frame(1'b0);
    rx_stop();
    drain(80, "t21_full");
    chk("t21_full_nwords", 32'(obs_data.size()), 32'(DP));
    chk("t21_full_drop", 32'(drop_cnt), 32'd1);

    // Two 8-byte frames held off by m_ready low, then released
    do_reset();
    clear_obs();
    m_ready = 1'b0;
    mk_seq(8'h01, 8);
    send_frame(1'b0);
    mk_seq(8'h09, 8);
    send_frame(1'b0);
    rx_stop();
    repeat (6) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t34_hold_valid", 32'(m_valid), 32'd1);
      chk("t34_hold_data", m_data, 32'h04030201);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain(40, "t34");
    chk("t34_nwords", 32'(obs_data.size()), 32'd4);
    if (obs_data.size() == 4) begin
      chk("t34_w0", obs_data[0], 32'h04030201);
      chk("t34_w1", obs_data[1], 32'h08070605);
      chk("t34_w2", obs_data[2], 32'h0C0B0A09);
      chk("t34_w3", obs_data[3], 32'h100F0E0D);
      for (int i = 0; i < 3; i++) chk("t34_consecutive", 32'(obs_cyc[i+1] - obs_cyc[i]), 32'd1);
    end

    // Reset in the middle of a frame
    drive_byte(8'hC1, 1'b0, 1'b0);
    drive_byte(8'hC2, 1'b0, 1'b0);
    drive_byte(8'hC3, 1'b0, 1'b0);
    do_reset();
    clear_obs();
    fb.delete();
    fb.push_back(8'h01);
    fb.push_back(8'h02);
    send_frame(1'b0);
    rx_stop();
    drain(40, "t35");
    chk("t35_nwords", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() == 1) begin
      chk("t35_data", obs_data[0], 32'h00000201);
      chk("t35_keep", 32'(obs_keep[0]), 32'h3);
      chk("t35_last", 32'(obs_last[0]), 32'd1);
    end

    // 20 back-to-back 4-byte frames, pointers wrap
    clear_obs();
    for (int k = 0; k < 20; k++) begin
      mk_seq(8'(4 * k + 1), 4);
      send_frame(1'b0);
    end
    rx_stop();
    drain(200, "t36");
    chk("t36_nwords", 32'(obs_data.size()), 32'd20);
    if (obs_data.size() == 20) begin
      chk("t36_first", obs_data[0], 32'h04030201);
      chk("t36_last_word", obs_data[19], 32'h504F4E4D);
    end
    chk("t36_drop", 32'(drop_cnt), 32'd0);
    chk("t36_fill", 32'(fill), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
